pulse_scheduler: RTL and testbench
==================================

// Module: pulse_scheduler
// PURPOSE
//  Shares one pulse-generator resource among N requesters. Requesters are granted
//  in round-robin order. The granted requester gets one output pulse of programmable
//  width on clk, followed by a programmable guard gap.
//  Sits between the system clock generator and any block that needs a timed strobe.
// PARAMETERS
//  N       4  number of requesters (2..8)
//  CNT_W   4  width of the pulse_len/gap_len fields and of the internal down-counter
// PORTS
//  clk        in   1      system clock, rising-edge
//  rst_n      in   1      asynchronous reset, active-low
//  req        in   N      level request per requester; held until ack
//  pulse_len  in   CNT_W  pulse width in clk cycles; 0 is treated as 1
//  gap_len    in   CNT_W  guard cycles after the pulse; 0 means no GAP state
//  pulse      out  1      shared pulse output, registered
//  grant      out  N      one-hot owner of the current pulse/gap; 0 in IDLE
//  ack        out  N      one-cycle strobe to the owner on the last pulse cycle
//  busy       out  1      high in PULSE or GAP
// BEHAVIOUR
//  - Reset (rst_n=0, async, immediate):
//    state=IDLE; pulse, grant, ack, busy = 0; counter=0; rr_ptr=N-1.
//  - All outputs are registered, decoded from state and counter.
//    No combinational path from input to output.
//  - FSM states: IDLE, PULSE, GAP.
//  - IDLE: at each rising edge, if req!=0, choose the winner as the first asserted
//    req scanning rr_ptr+1, rr_ptr+2, ... modulo N. Then:
//    grant=onehot(winner); rr_ptr=winner; cnt=max(pulse_len,1)-1;
//    latch gap_len into gap_q; go to PULSE.
//  - Latency: when req is sampled at edge k, pulse=1 and grant are valid
//    immediately after edge k.
//  - PULSE: pulse=1. Each edge: if cnt!=0 then cnt--. Else pulse ends; then
//    if gap_q!=0 go to GAP with cnt=gap_q-1, otherwise go to IDLE.
//    Total pulse width is exactly max(pulse_len,1) cycles.
//  - ack[winner]=1 only during the final PULSE cycle, i.e. the cycle in which cnt==0.
//  - GAP: pulse=0, grant held, busy=1. Each edge: if cnt!=0 then cnt--; else go to IDLE.
//    GAP lasts exactly gap_q cycles.
//  - Return to IDLE: grant=0, busy=0. At least one IDLE cycle always separates two
//    pulses, so back-to-back pulses have a low period of gap_q+1 cycles.
//  - pulse_len and gap_len are sampled only at grant. Changes during PULSE or GAP
//    have no effect on the transaction in progress.
//  - Owner drops req mid-pulse: the pulse and gap still complete and ack is still
//    issued. The grant is never aborted.
//  - Non-owner req changes during PULSE/GAP: ignored until IDLE.
//  - All N requesting continuously: grants rotate 0,1,2,...,N-1,0. No starvation;
//    worst-case wait is N-1 transactions.
//  - Single requester: it is re-granted after each IDLE cycle.
//  - Counter widths: cnt is CNT_W bits. Maximum pulse is 2^CNT_W-1 cycles;
//    maximum gap is 2^CNT_W-1 cycles. No wrap-around is possible.
//  - rst_n asserted mid-PULSE: pulse drops asynchronously with no ack.
//    After release, arbitration restarts from requester 0.
//  - Invariants:
//    grant is one-hot or zero; ack is a subset of grant; pulse implies busy.
// TESTING
//  1. Reset: hold rst_n=0 with req=4'b1111
//     -> pulse, grant, ack, busy = 0.
//     Release rst_n -> first grant is 4'b0001.
//  2. Single request: req=4'b0100, pulse_len=3, gap_len=2
//     -> pulse high 3 cycles; ack[2] on the 3rd cycle; busy 5 cycles;
//     grant=4'b0100 for 5 cycles.
//  3. Round-robin: req=4'b1111 held, pulse_len=1, gap_len=0
//     -> grant sequence 0001,0010,0100,1000,0001; pulse period 2 cycles.
//  4. Zero length: pulse_len=0, gap_len=0, req=4'b0001
//     -> 1-cycle pulse with ack[0] in the same cycle; then IDLE; no GAP state.
//  5. Mid-op changes: start pulse_len=4, change pulse_len to 1 at cycle 2 and drop req
//     -> pulse is still 4 cycles and ack is still issued.
//  6. Async reset mid-PULSE at cycle 2 of 5
//     -> pulse=0 immediately with no ack; after release, rr_ptr restarts at requester 0.

Source files
------------

// File: rtl/pulse_scheduler_if.sv
// Bundles the requester-side and pulse-side signals of the pulse scheduler.
// The scheduler sits on the slave modport; requesters drive through master.
interface pulse_scheduler_if #(
  parameter int N     = 4,
  parameter int CNT_W = 4
);
  logic [N-1:0]     req;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] gap_len;
  logic             pulse;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic             busy;

  modport master (
    output req, pulse_len, gap_len,
    input  pulse, grant, ack, busy
  );

  modport slave (
    input  req, pulse_len, gap_len,
    output pulse, grant, ack, busy
  );
endinterface

// File: rtl/pulse_scheduler.sv
// Round-robin shared pulse generator: one granted requester at a time receives
// a pulse of programmable width followed by a programmable guard gap.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no owner; arbitrate among requesters on every edge
//  PULSE | pulse high for max(pulse_len,1) cycles; ack on the last one
//  GAP   | pulse low, owner still granted, for gap_q cycles
module pulse_scheduler #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_scheduler_if.slave   bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] gap_q, gap_nxt;
  logic [N-1:0]     grant_q, grant_nxt;
  logic [PW-1:0]    rr_ptr, rr_nxt;
  logic             pulse_q, busy_q;
  logic [N-1:0]     ack_q;

  logic             found;
  logic [PW-1:0]    winner;
  int               idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // Next-state, counter and ownership decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap_q;
    grant_nxt = grant_q;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (found) begin
          state_nxt = PULSE;
          grant_nxt = N'(1) << winner;
          rr_nxt    = winner;
          cnt_nxt   = (bus.pulse_len == '0) ? '0 : bus.pulse_len - 1'b1;
          gap_nxt   = bus.gap_len;
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (gap_q != '0) begin
          state_nxt = GAP;
          cnt_nxt   = gap_q - 1'b1;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        grant_nxt = '0;
      end
    endcase
  end

  // State registers plus outputs registered from the next-state decode,
  // so pulse/grant appear right after the edge that sampled req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      rr_ptr  <= PW'(N - 1);
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_q   <= gap_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= rr_nxt;
      pulse_q <= (state_nxt == PULSE);
      busy_q  <= (state_nxt != IDLE);
      ack_q   <= (state_nxt == PULSE && cnt_nxt == '0) ? grant_nxt : '0;
    end
  end

  assign bus.pulse = pulse_q;
  assign bus.busy  = busy_q;
  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: stimulus pushes expected transactions,
// a negedge monitor reconstructs each observed transaction and compares.
module tb_pulse_scheduler;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] pw;
    logic [7:0] gw;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  logic       in_tx;
  logic [3:0] cur_grant;
  int         pw_cnt, gw_cnt;
  logic       ack_ok, grant_ok;
  logic [3:0] prev_ack, last_ack;

  pulse_scheduler_if #(.N(4), .CNT_W(4)) bus_if ();

  pulse_scheduler #(.N(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input int p, input int gp);
    exp_t e;
    e.grant = g;
    e.pw    = 8'(p);
    e.gw    = 8'(gp);
    sb.push_back(e);
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.ack == 4'b0 && n < 40);
    if (bus_if.ack == 4'b0) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || in_tx) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: invariants every cycle, transaction reconstruction and scoreboard pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_tx = 1'b0;
    end else begin
      checks++;
      if (!$onehot0(bus_if.grant) || ((bus_if.ack & ~bus_if.grant) != 4'b0) ||
          (bus_if.pulse && !bus_if.busy)) begin
        errors++;
        $display("FAIL invariant: grant=%b ack=%b pulse=%b busy=%b at %0t",
                 bus_if.grant, bus_if.ack, bus_if.pulse, bus_if.busy, $time);
      end
      if (bus_if.busy && !in_tx) begin
        in_tx     = 1'b1;
        cur_grant = bus_if.grant;
        pw_cnt    = 0;
        gw_cnt    = 0;
        ack_ok    = 1'b1;
        grant_ok  = 1'b1;
        prev_ack  = 4'b0;
        last_ack  = 4'b0;
      end
      if (in_tx && bus_if.busy) begin
        if (bus_if.grant != cur_grant) grant_ok = 1'b0;
        if (bus_if.pulse) begin
          if (gw_cnt != 0 || prev_ack != 4'b0) ack_ok = 1'b0;
          pw_cnt++;
          prev_ack = bus_if.ack;
          last_ack = bus_if.ack;
        end else begin
          gw_cnt++;
          if (bus_if.ack != 4'b0) ack_ok = 1'b0;
        end
      end else if (in_tx) begin
        in_tx = 1'b0;
        if (last_ack != cur_grant) ack_ok = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_tx", {28'd0, cur_grant}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tx_grant", {28'd0, cur_grant}, {28'd0, e.grant});
          chk("tx_pulse_width", 32'(pw_cnt), {24'd0, e.pw});
          chk("tx_gap_width", 32'(gw_cnt), {24'd0, e.gw});
          chk("tx_ack", {31'd0, ack_ok}, 32'd1);
          chk("tx_grant_held", {31'd0, grant_ok}, 32'd1);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    checks = 0;
    errors = 0;
    in_tx  = 1'b0;
    rst_n  = 1'b0;
    bus_if.req       = 4'b1111;
    bus_if.pulse_len = 4'd1;
    bus_if.gap_len   = 4'd0;

    // Reset held with all requesting: outputs quiet.
    repeat (3) @(negedge clk);
    chk("rst_pulse", {31'd0, bus_if.pulse}, 32'd0);
    chk("rst_grant", {28'd0, bus_if.grant}, 32'd0);
    chk("rst_ack", {28'd0, bus_if.ack}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);

    // Release with all requesting: rotation from requester 0, period 2.
    push(4'b0001, 1, 0);
    push(4'b0010, 1, 0);
    push(4'b0100, 1, 0);
    push(4'b1000, 1, 0);
    push(4'b0001, 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rr_pulse_pattern", {31'd0, bus_if.pulse}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus_if.req = 4'b0000;
    wait_drain("rr");

    // Single request with gap.
    bus_if.req       = 4'b0100;
    bus_if.pulse_len = 4'd3;
    bus_if.gap_len   = 4'd2;
    push(4'b0100, 3, 2);
    wait_ack("single");
    bus_if.req = 4'b0000;
    wait_drain("single");

    // Zero lengths: one-cycle pulse, no gap.
    bus_if.req       = 4'b0001;
    bus_if.pulse_len = 4'd0;
    bus_if.gap_len   = 4'd0;
    push(4'b0001, 1, 0);
    @(negedge clk);
    bus_if.req = 4'b0000;
    wait_drain("zero_len");

    // Lengths and req change mid-pulse: transaction unaffected.
    bus_if.req       = 4'b0010;
    bus_if.pulse_len = 4'd4;
    bus_if.gap_len   = 4'd1;
    push(4'b0010, 4, 1);
    repeat (2) @(negedge clk);
    bus_if.pulse_len = 4'd1;
    bus_if.gap_len   = 4'd0;
    bus_if.req       = 4'b0000;
    wait_drain("mid_change");

    // Single requester held: re-granted after each idle cycle.
    bus_if.req       = 4'b0001;
    bus_if.pulse_len = 4'd1;
    bus_if.gap_len   = 4'd1;
    push(4'b0001, 1, 1);
    push(4'b0001, 1, 1);
    push(4'b0001, 1, 1);
    wait_ack("regrant1");
    wait_ack("regrant2");
    wait_ack("regrant3");
    bus_if.req = 4'b0000;
    wait_drain("regrant");

    // Async reset in cycle 2 of a 5-cycle pulse, then arbitration restarts.
    bus_if.req       = 4'b0001;
    bus_if.pulse_len = 4'd5;
    bus_if.gap_len   = 4'd0;
    repeat (2) @(negedge clk);
    chk("pre_rst_pulse", {31'd0, bus_if.pulse}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pulse", {31'd0, bus_if.pulse}, 32'd0);
    chk("async_rst_ack", {28'd0, bus_if.ack}, 32'd0);
    chk("async_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("async_rst_grant", {28'd0, bus_if.grant}, 32'd0);
    repeat (2) @(negedge clk);
    bus_if.req       = 4'b1111;
    bus_if.pulse_len = 4'd2;
    bus_if.gap_len   = 4'd1;
    push(4'b0001, 2, 1);
    rst_n = 1'b1;
    wait_ack("post_rst");
    bus_if.req = 4'b0000;
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
